// File: rtl/uart_reg_cmd.sv
// UART byte-stream command decoder.
// Writes/reads a 4-entry byte register bank, drives LEDs and an error count.
module uart_reg_cmd #(
  parameter int CLK_HZ        = 50000000,
  parameter int BIT_RATE      = 11520,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [31:0] regs,
  output logic [3:0]  wr_strobe,
  output logic [3:0]  led,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  // one byte time is 10 bit times (start, 8 data, stop)
  localparam longint TO_L =
    (longint'(TIMEOUT_BYTES) * 64'sd10 * longint'(CLK_HZ))
    / longint'(BIT_RATE);
  localparam int TIMEOUT_CYC = int'(TO_L);
  localparam int CNT_W =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {
    IDLE,
    WAIT_VAL
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       idx;
  logic [1:0]       idx_n;

  logic [3:0][7:0]  reg_q;
  logic [3:0]       wr_stb;
  logic [7:0]       err_q;
  logic             rsp_v;
  logic [7:0]       rsp_d;

  logic             is_nul;
  logic             is_wr;
  logic             is_rd;
  logic [1:0]       sel;

  logic             wr_en;
  logic             err_ev;
  logic             rd_req;
  logic             hs;
  logic             rsp_load;
  logic             rsp_drop;
  logic             err_inc;

  // byte classification; "A".."D" and "a".."d" share low bits 01,10,11,00
  always_comb begin
    is_nul = (rx_data == 8'h00);
    is_wr  = (rx_data >= 8'h41) && (rx_data <= 8'h44);
    is_rd  = (rx_data >= 8'h61) && (rx_data <= 8'h64);
    sel    = rx_data[1:0] - 2'd1;
  end

  // next-state, timeout and command decode
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    wr_en   = 1'b0;
    err_ev  = 1'b0;
    rd_req  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            is_wr: begin
              idx_n   = sel;
              cnt_n   = '0;
              state_n = WAIT_VAL;
            end
            is_rd:   rd_req = 1'b1;
            is_nul:  ;
            default: err_ev = 1'b1;
          endcase
        end
      end
      WAIT_VAL: begin
        if (rx_valid) begin
          state_n = IDLE;
          if (is_nul) begin
            err_ev = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          err_ev  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // single-entry response slot: reload allowed on the handshake cycle
  always_comb begin
    hs       = rsp_v && rsp_ready;
    rsp_load = rd_req && (!rsp_v || hs);
    rsp_drop = rd_req && !rsp_load;
    err_inc  = err_ev || rsp_drop;
  end

  // state, timeout counter and pending write index
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // register bank and one-cycle write strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q  <= '0;
      wr_stb <= '0;
    end else begin
      wr_stb <= '0;
      if (wr_en) begin
        reg_q[idx] <= rx_data;
        wr_stb     <= 4'b0001 << idx;
      end
    end
  end

  // response holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_v <= 1'b0;
      rsp_d <= '0;
    end else if (rsp_load) begin
      rsp_v <= 1'b1;
      rsp_d <= reg_q[sel];
    end else if (hs) begin
      rsp_v <= 1'b0;
    end
  end

  // saturating error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (err_inc && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  // LEDs mirror bit 0 of each register
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      led[n] = reg_q[n][0];
    end
  end

  assign regs      = reg_q;
  assign wr_strobe = wr_stb;
  assign err_cnt   = err_q;
  assign rsp_valid = rsp_v;
  assign rsp_data  = rsp_d;
  assign busy      = (state == WAIT_VAL);

endmodule

// File: tb/tb_uart_reg_cmd.sv
// Scoreboard bench for uart_reg_cmd.
// Small clock/bit-rate parameters shorten the timeout to 400 cycles.
module tb_uart_reg_cmd;

  localparam int TO = 4 * 10 * 1000 / 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_data;
  logic [31:0] regs;
  logic [3:0]  wr_strobe;
  logic [3:0]  led;
  logic [7:0]  err_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;

  logic [7:0] exp_rsp[$];
  logic [3:0] stb_log[$];

  uart_reg_cmd #(
    .CLK_HZ(1000),
    .BIT_RATE(100),
    .TIMEOUT_BYTES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .regs(regs),
    .wr_strobe(wr_strobe),
    .led(led),
    .err_cnt(err_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // caller sits on a negedge; byte is taken at the next posedge
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor: response handshakes against the scoreboard, strobe logging
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && rsp_valid && rsp_ready) begin
        hs_cnt++;
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", {24'h0, rsp_data}, 32'hFFFF_FFFF);
        end else begin
          chk("rsp_data", {24'h0, rsp_data},
              {24'h0, exp_rsp.pop_front()});
        end
      end
      if (wr_strobe != 4'h0) begin
        stb_log.push_back(wr_strobe);
      end
    end
  end

  initial begin
    logic [3:0] stb_exp[4];
    int stb_n;
    stb_exp = '{4'h1, 4'h2, 4'h4, 4'h8};

    @(negedge clk);
    pulse_reset();
    chk("rst_regs", regs, 32'h0);
    chk("rst_err", {24'h0, err_cnt}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_strobe", {28'h0, wr_strobe}, 32'h0);

    // writes
    send("A"); chk("busy_wait", {31'h0, busy}, 32'h1);
    send("1"); chk("stb0", {28'h0, wr_strobe}, 32'h1);
    send("B"); send("2");
    send("C"); send("3");
    send("D"); send("4");
    idle(2);
    chk("regs_wr", regs, 32'h3433_3231);
    chk("led_wr", {28'h0, led}, 32'h5);
    chk("err_wr", {24'h0, err_cnt}, 32'h0);
    chk("stb_count", stb_log.size(), 4);
    for (int i = 0; i < 4 && i < stb_log.size(); i++) begin
      chk("stb_seq", {28'h0, stb_log[i]}, {28'h0, stb_exp[i]});
    end

    // reads with ready held high
    for (int i = 0; i < 4; i++) begin
      logic [7:0] c;
      c = 8'h61 + 8'(i);
      exp_rsp.push_back(8'h31 + 8'(i));
      send(c);
      chk("rd_valid_hi", {31'h0, rsp_valid}, 32'h1);
      @(negedge clk);
      chk("rd_valid_lo", {31'h0, rsp_valid}, 32'h0);
    end
    chk("rd_hs", hs_cnt, 4);

    // back-pressure
    rsp_ready = 1'b0;
    exp_rsp.push_back(8'h31);
    send("a");
    send("b");
    idle(3);
    chk("bp_data", {24'h0, rsp_data}, 32'h31);
    chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("bp_err", {24'h0, err_cnt}, 32'h1);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {31'h0, rsp_valid}, 32'h0);
    chk("bp_hs", hs_cnt, 5);

    // abort and garbage
    stb_n = stb_log.size();
    send("B"); send(8'h00);
    chk("abort_reg1", {24'h0, regs[15:8]}, 32'h32);
    chk("abort_err", {24'h0, err_cnt}, 32'h2);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    send("Z");
    chk("garbage_err", {24'h0, err_cnt}, 32'h3);
    send(8'h00);
    chk("nul_idle_err", {24'h0, err_cnt}, 32'h3);
    chk("nul_idle_regs", regs, 32'h3433_3231);

    // timeout: still busy one cycle before the terminal count
    send("C");
    idle(TO - 1);
    chk("to_busy_edge", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("to_busy", {31'h0, busy}, 32'h0);
    chk("to_err", {24'h0, err_cnt}, 32'h4);
    chk("to_no_stb", stb_log.size(), stb_n);
    send("5");
    chk("to_garbage", {24'h0, err_cnt}, 32'h5);
    chk("to_regs", regs, 32'h3433_3231);

    // byte arriving on the terminal-count cycle wins
    send("D");
    idle(TO - 1);
    send("9");
    chk("tc_reg3", {24'h0, regs[31:24]}, 32'h39);
    chk("tc_stb", {28'h0, wr_strobe}, 32'h8);
    chk("tc_err", {24'h0, err_cnt}, 32'h5);

    // saturation
    for (int i = 0; i < 260; i++) send("Z");
    chk("sat_err", {24'h0, err_cnt}, 32'hFF);

    // reset mid-write
    send("A");
    pulse_reset();
    chk("rm_busy", {31'h0, busy}, 32'h0);
    chk("rm_regs", regs, 32'h0);
    chk("rm_err", {24'h0, err_cnt}, 32'h0);
    send("7");
    chk("rm_garbage", {24'h0, err_cnt}, 32'h1);
    chk("rm_regs2", regs, 32'h0);

    idle(2);
    chk("sb_empty", exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_reg_cmd.md
Name: uart_reg_cmd

Overview:
- Byte-stream command decoder between the UART receiver and the board-level register/LED logic in impl_top.
- Consumes received bytes as a one-cycle valid strobe and decodes them:
  - "A".."D" followed by a value byte writes register 0..3.
  - "a".."d" reads register 0..3 back through a valid/ready response port.
  - 0x00 is a terminator/abort.
- Drives the register bank, the green LEDs and a saturating error counter.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BIT_RATE, 11520, UART bit rate. Used only to derive the timeout.
- TIMEOUT_BYTES, 4, inter-byte timeout in byte times. TIMEOUT_CYC = TIMEOUT_BYTES*10*CLK_HZ/BIT_RATE, computed at elaboration.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer accepts the response when rsp_valid && rsp_ready.
- rsp_data  out  8  read response byte.
- regs  out  32  register bank; reg n is at bits [8n+7:8n].
- wr_strobe  out  4  one-cycle pulse on bit n when reg n is written.
- led  out  4  led[n] = bit 0 of reg n.
- err_cnt  out  8  saturating error count.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset (synchronous, dominates all other inputs) sets the following; it also drops any pending response and aborts a half-received write:
  - state = IDLE
  - regs = 0, wr_strobe = 0, err_cnt = 0
  - rsp_valid = 0, rsp_data = 0
  - timeout counter = 0
- States are IDLE and WAIT_VAL. Bytes are sampled only on cycles where rx_valid = 1.
- In IDLE:
  - 0x41..0x44 ("A".."D"): latch index = byte-0x41, go to WAIT_VAL, clear the timeout counter.
  - 0x61..0x64 ("a".."d"): read request, see response rules below. Stay in IDLE.
  - 0x00: no-op.
  - Any other byte: err_cnt+1.
- In WAIT_VAL:
  - Any nonzero byte: write it raw to reg[index]. The new value is visible on regs/led the cycle after rx_valid. wr_strobe[index] = 1 in that same cycle only. Return to IDLE.
  - 0x00: abort, no write, err_cnt+1, go to IDLE. Value 0x00 is therefore not writable via UART.
  - Timeout: the counter increments each cycle without rx_valid. On reaching TIMEOUT_CYC-1: err_cnt+1, go to IDLE, no write.
  - rx_valid in the same cycle as the terminal count: the byte wins and the write proceeds.
- Response rules (single-entry holding register):
  - Read request while rsp_valid = 0: rsp_data = reg[n], rsp_valid = 1 the next cycle.
  - rsp_data holds steady while rsp_valid && !rsp_ready.
  - rsp_valid falls the cycle after the handshake.
  - Read request in the same cycle as the handshake: the new response is loaded and rsp_valid stays 1.
  - Read request while rsp_valid && !rsp_ready: request dropped, err_cnt+1.
  - A read returns the register value before any write committing in the same cycle. This case cannot arise, since writes and reads need distinct rx bytes.
- err_cnt saturates at 255 and never wraps.
- A read request in IDLE does not change state. busy = 1 only in WAIT_VAL.

Test Plan:
- Writes: reset, then bytes "A","1","B","2","C","3","D","4" → regs = 0x34333231, led = 4'b0101, four single-cycle wr_strobe pulses 1,2,4,8, err_cnt = 0.
- Reads: after the writes, "a","b","c","d" with rsp_ready held 1 → responses 0x31,0x32,0x33,0x34 in order, each rsp_valid high for exactly one cycle.
- Back-pressure: rsp_ready = 0, send "a" then "b" → rsp_data stays 0x31, err_cnt = 1. Raise rsp_ready → one handshake, then rsp_valid = 0.
- Abort/garbage: "B",0x00 → reg1 unchanged, err_cnt+1. "Z" → err_cnt+1. 0x00 in IDLE → no change.
- Timeout: "C", then silence for TIMEOUT_CYC cycles → state IDLE, err_cnt+1, no wr_strobe. A later "5" is treated as garbage (err_cnt+1).
- Reset mid-write: "A" then reset pulse → busy = 0, regs = 0. A following "7" is garbage, not a write.
